// File: rtl/button_debounce.sv
// button_debounce: per-channel two-flop synchroniser followed by a
// saturating stability counter. Outputs are a clean registered level plus
// one-cycle rise/fall pulses. Channels are fully independent.
module button_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter bit INVERT          = 1'b0,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_clean,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    // Terminal count: the mismatch must still be present when cnt reaches this.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Polarity normalisation ahead of the synchroniser; afterwards 1 means pressed.
    logic [WIDTH-1:0] btn_in;
    assign btn_in = INVERT ? ~btn_raw : btn_raw;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic             sync1_q;
            logic             sync2_q;
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             clean_q;
            logic             clean_d;
            logic             rise_q;
            logic             rise_d;
            logic             fall_q;
            logic             fall_d;
            logic             mismatch;

            assign mismatch = (sync2_q != clean_q);

            // Two-flop synchroniser; only sync2 feeds the debounce logic.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    sync1_q <= btn_in[gi];
                    sync2_q <= sync1_q;
                end
            end

            // Next-state logic: count consecutive mismatch cycles, flip on terminal count.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                clean_d = clean_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                case (state_q)
                    ST_STABLE: begin
                        cnt_d = '0;
                        if (mismatch) begin
                            state_d = ST_COUNT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    ST_COUNT: begin
                        if (!mismatch) begin
                            // Bounced back before the window closed: discard.
                            state_d = ST_STABLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = ST_STABLE;
                            cnt_d   = '0;
                            clean_d = sync2_q;
                            rise_d  = sync2_q;
                            fall_d  = ~sync2_q;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // State, counter and registered outputs.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                    clean_q <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    clean_q <= clean_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign btn_clean[gi] = clean_q;
            assign btn_rise[gi]  = rise_q;
            assign btn_fall[gi]  = fall_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed scenarios for button_debounce with
// DEBOUNCE_CYCLES=4. Inputs change and outputs are sampled on the falling
// edge; j counts rising edges after the edge that first samples a new level
// (j=0), so outputs change at j = 1 + DEBOUNCE_CYCLES = 5.
module tb_button_debounce;

    localparam int W = 2;
    localparam int D = 4;
    localparam int LAT = 1 + D;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] btn_raw;
    logic [W-1:0] btn_clean;
    logic [W-1:0] btn_rise;
    logic [W-1:0] btn_fall;

    int checks;
    int errors;

    button_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .INVERT(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .btn_clean(btn_clean),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [W-1:0] exp_clean;
        logic [W-1:0] exp_rise;
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_rise, btn_fall} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold c=%0d clean=%b rise=%b fall=%b expected all 0",
                         c, btn_clean, btn_rise, btn_fall);
            end
        end
        rst_n = 1'b1;
        for (int j = 0; j <= 7; j++) begin
            @(negedge clk);
            exp_clean = (j >= LAT) ? 2'b11 : 2'b00;
            exp_rise  = (j == LAT) ? 2'b11 : 2'b00;
            checks++;
            if (btn_clean !== exp_clean || btn_rise !== exp_rise || btn_fall !== 2'b00) begin
                errors++;
                $display("FAIL reset_release j=%0d clean=%b rise=%b fall=%b expected %b %b 00",
                         j, btn_clean, btn_rise, btn_fall, exp_clean, exp_rise);
            end
        end
    endtask

    task automatic test_press_release();
        logic [W-1:0] exp_clean;
        logic [W-1:0] exp_rise;
        logic [W-1:0] exp_fall;
        rst_n = 1'b0; btn_raw = 2'b00;
        @(negedge clk);
        rst_n   = 1'b1;
        btn_raw = 2'b01;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            exp_clean = (j >= LAT) ? 2'b01 : 2'b00;
            exp_rise  = (j == LAT) ? 2'b01 : 2'b00;
            checks++;
            if (btn_clean !== exp_clean || btn_rise !== exp_rise || btn_fall !== 2'b00) begin
                errors++;
                $display("FAIL press j=%0d clean=%b rise=%b fall=%b expected %b %b 00",
                         j, btn_clean, btn_rise, btn_fall, exp_clean, exp_rise);
            end
        end
        btn_raw = 2'b00;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            exp_clean = (j >= LAT) ? 2'b00 : 2'b01;
            exp_fall  = (j == LAT) ? 2'b01 : 2'b00;
            checks++;
            if (btn_clean !== exp_clean || btn_fall !== exp_fall || btn_rise !== 2'b00) begin
                errors++;
                $display("FAIL release j=%0d clean=%b rise=%b fall=%b expected %b 00 %b",
                         j, btn_clean, btn_rise, btn_fall, exp_clean, exp_fall);
            end
        end
    endtask

    task automatic test_bounce_reject();
        logic [5:0] pattern;
        pattern = 6'b101101;  // applied MSB first: 1,0,1,1,0,1
        rst_n = 1'b0; btn_raw = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 14; j++) begin
            btn_raw = {(j < 6) ? pattern[5 - j] : 1'b0, 1'b0};
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_rise, btn_fall} !== 6'b0) begin
                errors++;
                $display("FAIL bounce_reject j=%0d clean=%b rise=%b fall=%b expected all 0",
                         j, btn_clean, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_bounce_settle();
        logic [3:0] pattern;
        logic [W-1:0] exp_clean;
        logic [W-1:0] exp_rise;
        pattern = 4'b1010;  // applied MSB first: 1,0,1,0
        rst_n = 1'b0; btn_raw = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            btn_raw = {1'b0, pattern[3 - p]};
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_rise, btn_fall} !== 6'b0) begin
                errors++;
                $display("FAIL settle_bounce p=%0d clean=%b rise=%b fall=%b expected all 0",
                         p, btn_clean, btn_rise, btn_fall);
            end
        end
        btn_raw = 2'b01;
        for (int j = 0; j <= 7; j++) begin
            @(negedge clk);
            exp_clean = (j >= LAT) ? 2'b01 : 2'b00;
            exp_rise  = (j == LAT) ? 2'b01 : 2'b00;
            checks++;
            if (btn_clean !== exp_clean || btn_rise !== exp_rise || btn_fall !== 2'b00) begin
                errors++;
                $display("FAIL settle_hold j=%0d clean=%b rise=%b fall=%b expected %b %b 00",
                         j, btn_clean, btn_rise, btn_fall, exp_clean, exp_rise);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] exp_clean;
        logic [W-1:0] exp_rise;
        rst_n = 1'b0; btn_raw = 2'b00;
        @(negedge clk);
        rst_n   = 1'b1;
        btn_raw = 2'b11;
        for (int j = 0; j <= 7; j++) begin
            @(negedge clk);
            exp_clean = (j >= LAT) ? 2'b11 : 2'b00;
            exp_rise  = (j == LAT) ? 2'b11 : 2'b00;
            checks++;
            if (btn_clean !== exp_clean || btn_rise !== exp_rise || btn_fall !== 2'b00) begin
                errors++;
                $display("FAIL simultaneous j=%0d clean=%b rise=%b fall=%b expected %b %b 00",
                         j, btn_clean, btn_rise, btn_fall, exp_clean, exp_rise);
            end
        end
    endtask

    // A 3-cycle pulse (D-1) must vanish; a 4-cycle pulse (D) must pass and
    // fall back exactly D cycles later.
    task automatic test_boundary_glitch();
        logic [W-1:0] exp_clean;
        logic [W-1:0] exp_rise;
        logic [W-1:0] exp_fall;
        rst_n = 1'b0; btn_raw = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            btn_raw = (j < D - 1) ? 2'b01 : 2'b00;
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_rise, btn_fall} !== 6'b0) begin
                errors++;
                $display("FAIL glitch_short j=%0d clean=%b rise=%b fall=%b expected all 0",
                         j, btn_clean, btn_rise, btn_fall);
            end
        end
        for (int j = 0; j <= 11; j++) begin
            btn_raw = (j < D) ? 2'b01 : 2'b00;
            @(negedge clk);
            exp_clean = (j >= LAT && j < LAT + D) ? 2'b01 : 2'b00;
            exp_rise  = (j == LAT) ? 2'b01 : 2'b00;
            exp_fall  = (j == LAT + D) ? 2'b01 : 2'b00;
            checks++;
            if (btn_clean !== exp_clean || btn_rise !== exp_rise || btn_fall !== exp_fall) begin
                errors++;
                $display("FAIL glitch_exact j=%0d clean=%b rise=%b fall=%b expected %b %b %b",
                         j, btn_clean, btn_rise, btn_fall, exp_clean, exp_rise, exp_fall);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [W-1:0] exp_clean;
        logic [W-1:0] exp_rise;
        rst_n = 1'b0; btn_raw = 2'b00;
        @(negedge clk);
        rst_n   = 1'b1;
        btn_raw = 2'b01;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({btn_clean, btn_rise, btn_fall} !== 6'b0) begin
            errors++;
            $display("FAIL midcount_reset clean=%b rise=%b fall=%b expected all 0",
                     btn_clean, btn_rise, btn_fall);
        end
        rst_n = 1'b1;
        for (int j = 0; j <= 7; j++) begin
            @(negedge clk);
            exp_clean = (j >= LAT) ? 2'b01 : 2'b00;
            exp_rise  = (j == LAT) ? 2'b01 : 2'b00;
            checks++;
            if (btn_clean !== exp_clean || btn_rise !== exp_rise || btn_fall !== 2'b00) begin
                errors++;
                $display("FAIL midcount_restart j=%0d clean=%b rise=%b fall=%b expected %b %b 00",
                         j, btn_clean, btn_rise, btn_fall, exp_clean, exp_rise);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        btn_raw = 2'b00;
        test_reset();
        test_press_release();
        test_bounce_reject();
        test_bounce_settle();
        test_simultaneous();
        test_boundary_glitch();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
